// File: rtl/pom_new_task_arbiter_if.sv
// Stream bundle around the new-task arbiter: one request lane per accelerator in, one merged lane out.
// The master modport is the arbiter's view; slave is the accelerators-plus-gateway view.
interface pom_new_task_arbiter_if #(
   parameter int NUM_ACCS = 16
);
   logic [NUM_ACCS-1:0]    acc_tvalid;
   logic [NUM_ACCS-1:0]    acc_tready;
   logic [64*NUM_ACCS-1:0] acc_tdata;
   logic [NUM_ACCS-1:0]    acc_tlast;
   logic [5*NUM_ACCS-1:0]  acc_tdest;

   logic                   out_tvalid;
   logic                   out_tready;
   logic [63:0]            out_tdata;
   logic                   out_tlast;
   logic [4:0]             out_tid;
   logic [4:0]             out_tdest;

   modport master (
      input  acc_tvalid, acc_tdata, acc_tlast, acc_tdest, out_tready,
      output acc_tready, out_tvalid, out_tdata, out_tlast, out_tid, out_tdest
   );

   modport slave (
      output acc_tvalid, acc_tdata, acc_tlast, acc_tdest, out_tready,
      input  acc_tready, out_tvalid, out_tdata, out_tlast, out_tid, out_tdest
   );
endinterface

// File: rtl/pom_new_task_arbiter.sv
// Round-robin packet arbiter merging accelerator new-task streams into the gateway input,
// holding each grant for a whole packet and tagging every beat with the source port in tid.
module pom_new_task_arbiter #(
   parameter  int NUM_ACCS = 16,
   localparam int PTR_W    = $clog2(NUM_ACCS)
) (
   input  logic                   clk,
   input  logic                   rst,
   pom_new_task_arbiter_if.master bus
);

   localparam int CW = PTR_W + 1;

   typedef enum logic {
      IDLE,
      XFER
   } state_t;

   state_t           state;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] grant;

   logic             out_tvalid_q;
   logic [63:0]      out_tdata_q;
   logic             out_tlast_q;
   logic [4:0]       out_tid_q;
   logic [4:0]       out_tdest_q;

   logic             req_found;
   logic [PTR_W-1:0] req_idx;
   logic [CW-1:0]    cand;

   logic             can_load;
   logic             accept;
   logic [63:0]      sel_data;
   logic [4:0]       sel_dest;
   logic             sel_last;
   logic [NUM_ACCS-1:0] acc_tready_c;

   // Scan downward so the last hit, i.e. the lowest offset from rr_ptr, wins.
   always_comb begin
      // NOTE: every signal written here gets a default first; a missed path would infer a latch.
      req_found = 1'b0;
      req_idx   = '0;
      cand      = '0;
      for (int i = NUM_ACCS - 1; i >= 0; i--) begin
         cand = {1'b0, rr_ptr} + CW'(i);
         if (cand >= CW'(NUM_ACCS)) begin
            cand = cand - CW'(NUM_ACCS);
         end
         if (bus.acc_tvalid[cand[PTR_W-1:0]]) begin
            req_found = 1'b1;
            req_idx   = cand[PTR_W-1:0];
         end
      end
   end

   assign can_load = !out_tvalid_q || bus.out_tready;
   assign sel_data = bus.acc_tdata[int'(grant)*64 +: 64];
   assign sel_dest = bus.acc_tdest[int'(grant)*5 +: 5];
   assign sel_last = bus.acc_tlast[grant];
   assign accept   = (state == XFER) && bus.acc_tvalid[grant] && can_load;

   always_comb begin
      acc_tready_c = '0;
      if (state == XFER) begin
         acc_tready_c[grant] = can_load;
      end
   end

   // NOTE: state registers use <= so every reader sees the pre-edge value regardless of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         grant        <= '0;
         out_tvalid_q <= 1'b0;
         out_tdata_q  <= '0;
         out_tlast_q  <= 1'b0;
         out_tid_q    <= '0;
         out_tdest_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_found) begin
                  grant <= req_idx;
                  state <= XFER;
               end
            end
            XFER: begin
               if (accept && sel_last) begin
                  rr_ptr <= (grant == PTR_W'(NUM_ACCS - 1)) ? '0 : grant + 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // A load in the same cycle as a drain simply replaces the buffered beat.
         if (accept) begin
            out_tvalid_q <= 1'b1;
            out_tdata_q  <= sel_data;
            out_tlast_q  <= sel_last;
            out_tid_q    <= 5'(grant);
            out_tdest_q  <= sel_dest;
         end else if (bus.out_tready) begin
            out_tvalid_q <= 1'b0;
         end
      end
   end

   assign bus.acc_tready = acc_tready_c;
   assign bus.out_tvalid = out_tvalid_q;
   assign bus.out_tdata  = out_tdata_q;
   assign bus.out_tlast  = out_tlast_q;
   assign bus.out_tid    = out_tid_q;
   assign bus.out_tdest  = out_tdest_q;

   a_ready_onehot: assert property (@(posedge clk) $onehot0(acc_tready_c));

   a_out_hold: assert property (@(posedge clk) disable iff (rst)
      (out_tvalid_q && !bus.out_tready) |=>
         $stable({out_tvalid_q, out_tdata_q, out_tlast_q, out_tid_q, out_tdest_q}));

endmodule

// File: tb/tb_pom_new_task_arbiter.sv
// Directed bench for pom_new_task_arbiter: a per-cycle vector table plus hand-written
// backpressure and all-ports round-robin sequences.
module tb_pom_new_task_arbiter;

   localparam int N = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   pom_new_task_arbiter_if #(.NUM_ACCS(N)) bus ();

   pom_new_task_arbiter #(.NUM_ACCS(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   typedef struct {
      logic          rs;
      logic [N-1:0]  v;
      logic [N-1:0]  l;
      logic          r;
      logic [63:0]   dat;
      logic [N-1:0]  tr;
      logic          ov;
      logic [63:0]   od;
      logic          ol;
      logic [4:0]    ot;
   } vec_t;

   vec_t vt[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Port i carries tdata = dat | (i << 32) and tdest = i + 15.
   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic r,
                        input logic [63:0] dat);
      bus.acc_tvalid = v;
      bus.acc_tlast  = l;
      bus.out_tready = r;
      for (int i = 0; i < N; i++) begin
         bus.acc_tdata[64*i +: 64] = dat | (64'(i) << 32);
         bus.acc_tdest[5*i +: 5]   = 5'(i + 15);
      end
   endtask

   task automatic add(input logic rs, input logic [N-1:0] v, input logic [N-1:0] l,
                      input logic r, input logic [63:0] dat, input logic [N-1:0] tr,
                      input logic ov, input logic [63:0] od, input logic ol,
                      input logic [4:0] ot);
      vec_t x;
      x.rs = rs; x.v = v; x.l = l; x.r = r; x.dat = dat;
      x.tr = tr; x.ov = ov; x.od = od; x.ol = ol; x.ot = ot;
      vt.push_back(x);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive('0, '0, 1'b1, '0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] exp_tr;
      logic         exp_ov;
      logic         rdy;
      logic         prev_stall;
      int           beat;
      int           exp_i;
      int           exp_id;

      //   rs  valid    last     r  dat        tready   ov od                   ol ot
      // Port 3, three beats, tdest 0x12; rr_ptr ends at 4.
      add(0, 'h0008, 'h0000, 1, 'h11,     'h0000, 0, 64'h0,                0, 0);
      add(0, 'h0008, 'h0000, 1, 'h11,     'h0008, 0, 64'h0,                0, 0);
      add(0, 'h0008, 'h0000, 1, 'h22,     'h0008, 1, 64'h3_0000_0011,      0, 3);
      add(0, 'h0008, 'h0008, 1, 'h33,     'h0008, 1, 64'h3_0000_0022,      0, 3);
      add(0, 'h0000, 'h0000, 1, 'h00,     'h0000, 1, 64'h3_0000_0033,      1, 3);
      // Ports 2 and 5 with rr_ptr=4: 5 first, then 2.
      add(0, 'h0024, 'h0024, 1, 'h44,     'h0000, 0, 64'h0,                0, 0);
      add(0, 'h0024, 'h0024, 1, 'h44,     'h0020, 0, 64'h0,                0, 0);
      add(0, 'h0004, 'h0004, 1, 'h55,     'h0000, 1, 64'h5_0000_0044,      1, 5);
      add(0, 'h0004, 'h0004, 1, 'h55,     'h0004, 0, 64'h0,                0, 0);
      add(0, 'h0000, 'h0000, 1, 'h00,     'h0000, 1, 64'h2_0000_0055,      1, 2);
      add(1, 'h0000, 'h0000, 1, 'h00,     'h0000, 0, 64'h0,                0, 0);
      // Ports 0 and 5, two beats each, rr_ptr=0: no interleaving.
      add(0, 'h0021, 'h0000, 1, 'h01,     'h0000, 0, 64'h0,                0, 0);
      add(0, 'h0021, 'h0000, 1, 'h01,     'h0001, 0, 64'h0,                0, 0);
      add(0, 'h0021, 'h0001, 1, 'h02,     'h0001, 1, 64'h0_0000_0001,      0, 0);
      add(0, 'h0020, 'h0000, 1, 'h03,     'h0000, 1, 64'h0_0000_0002,      1, 0);
      add(0, 'h0020, 'h0000, 1, 'h03,     'h0020, 0, 64'h0,                0, 0);
      add(0, 'h0020, 'h0020, 1, 'h04,     'h0020, 1, 64'h5_0000_0003,      0, 5);
      add(0, 'h0000, 'h0000, 1, 'h00,     'h0000, 1, 64'h5_0000_0004,      1, 5);
      // Port 14 moves rr_ptr to 15; then 15 and 1 compete and the pointer wraps.
      add(0, 'h4000, 'h4000, 1, 'h66,     'h0000, 0, 64'h0,                0, 0);
      add(0, 'h4000, 'h4000, 1, 'h66,     'h4000, 0, 64'h0,                0, 0);
      add(0, 'h8002, 'h8002, 1, 'h77,     'h0000, 1, 64'hE_0000_0066,      1, 14);
      add(0, 'h8002, 'h8002, 1, 'h77,     'h8000, 0, 64'h0,                0, 0);
      add(0, 'h0002, 'h0002, 1, 'h88,     'h0000, 1, 64'hF_0000_0077,      1, 15);
      add(0, 'h0002, 'h0002, 1, 'h88,     'h0002, 0, 64'h0,                0, 0);
      add(0, 'h0000, 'h0000, 1, 'h00,     'h0000, 1, 64'h1_0000_0088,      1, 1);
      add(0, 'h0000, 'h0000, 1, 'h00,     'h0000, 0, 64'h0,                0, 0);
      // Port 4 drops tvalid mid-packet while port 6 requests: grant is held.
      add(0, 'h0050, 'h0000, 1, 'h90,     'h0000, 0, 64'h0,                0, 0);
      add(0, 'h0050, 'h0000, 1, 'h90,     'h0010, 0, 64'h0,                0, 0);
      add(0, 'h0040, 'h0000, 1, 'h90,     'h0010, 1, 64'h4_0000_0090,      0, 4);
      add(0, 'h0040, 'h0000, 1, 'h90,     'h0010, 0, 64'h0,                0, 0);
      add(0, 'h0050, 'h0050, 1, 'h91,     'h0010, 0, 64'h0,                0, 0);
      add(0, 'h0040, 'h0040, 1, 'h92,     'h0000, 1, 64'h4_0000_0091,      1, 4);
      add(0, 'h0040, 'h0040, 1, 'h92,     'h0040, 0, 64'h0,                0, 0);
      add(0, 'h0000, 'h0000, 1, 'h00,     'h0000, 1, 64'h6_0000_0092,      1, 6);
      // Port 7 reset during beat 2 with rr_ptr=7; afterwards rr_ptr=0 picks port 2 before 7.
      add(0, 'h0080, 'h0000, 1, 'hA0,     'h0000, 0, 64'h0,                0, 0);
      add(0, 'h0080, 'h0000, 1, 'hA0,     'h0080, 0, 64'h0,                0, 0);
      add(0, 'h0080, 'h0000, 1, 'hA1,     'h0080, 1, 64'h7_0000_00A0,      0, 7);
      add(1, 'h0080, 'h0000, 1, 'hA2,     'h0080, 1, 64'h7_0000_00A1,      0, 7);
      add(0, 'h0084, 'h0004, 1, 'hB0,     'h0000, 0, 64'h0,                0, 0);
      add(0, 'h0084, 'h0084, 1, 'hB0,     'h0004, 0, 64'h0,                0, 0);
      add(0, 'h0080, 'h0080, 1, 'hB1,     'h0000, 1, 64'h2_0000_00B0,      1, 2);
      add(0, 'h0080, 'h0080, 1, 'hB1,     'h0080, 0, 64'h0,                0, 0);
      add(0, 'h0000, 'h0000, 1, 'h00,     'h0000, 1, 64'h7_0000_00B1,      1, 7);

      rst = 1'b1;
      drive('0, '0, 1'b1, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_tready", 128'(bus.acc_tready), 128'(0));
      check("reset_out", 128'({bus.out_tvalid, bus.out_tdata, bus.out_tlast,
                               bus.out_tid, bus.out_tdest}), 128'(0));

      for (int k = 0; k < vt.size(); k++) begin
         @(negedge clk);
         rst = vt[k].rs;
         drive(vt[k].v, vt[k].l, vt[k].r, vt[k].dat);
         #1;
         check($sformatf("vec%0d_tready", k), 128'(bus.acc_tready), 128'(vt[k].tr));
         if (vt[k].ov) begin
            check($sformatf("vec%0d_out", k),
                  128'({bus.out_tvalid, bus.out_tdata, bus.out_tlast, bus.out_tid, bus.out_tdest}),
                  128'({1'b1, vt[k].od, vt[k].ol, vt[k].ot, 5'(vt[k].ot + 5'd15)}));
         end else begin
            check($sformatf("vec%0d_ovalid", k), 128'(bus.out_tvalid), 128'(0));
         end
      end

      // Port 2 streams eight beats while out_tready cycles 1,0,0,1.
      do_reset();
      beat       = 0;
      exp_i      = 0;
      prev_stall = 1'b0;
      for (int c = 0; c < 60 && exp_i < 8; c++) begin
         @(negedge clk);
         rdy = (c % 4 == 0) || (c % 4 == 3);
         drive((beat < 8) ? N'('h0004) : '0, (beat == 7) ? N'('h0004) : '0, rdy, 64'(beat));
         #1;
         if (prev_stall) begin
            check("stall_ovalid_held", 128'(bus.out_tvalid), 128'(1));
         end
         if (bus.out_tvalid && !rdy) begin
            check("stall_ready_low", 128'(bus.acc_tready), 128'(0));
         end
         if (bus.out_tvalid) begin
            check($sformatf("stall_beat%0d", exp_i), 128'({bus.out_tdata, bus.out_tlast, bus.out_tid}),
                  128'({64'(exp_i) | 64'h2_0000_0000, exp_i == 7, 5'd2}));
            if (rdy) exp_i++;
         end
         prev_stall = bus.out_tvalid && !rdy;
         if (bus.acc_tvalid[2] && bus.acc_tready[2]) beat++;
      end
      check("stall_beat_count", 128'(exp_i), 128'(8));

      // Every port sends single-beat packets continuously: tid walks 0..15 twice, 2 cycles each.
      do_reset();
      for (int c = 0; c < 66; c++) begin
         @(negedge clk);
         drive('1, '1, 1'b1, 64'h0);
         #1;
         exp_tr = (c % 2 == 1) ? (N'(1) << (((c - 1) / 2) % N)) : '0;
         exp_ov = (c >= 2) && (c % 2 == 0);
         check($sformatf("rr%0d_tready", c), 128'(bus.acc_tready), 128'(exp_tr));
         check($sformatf("rr%0d_ovalid", c), 128'(bus.out_tvalid), 128'(exp_ov));
         if (exp_ov) begin
            exp_id = (c / 2 - 1) % N;
            check($sformatf("rr%0d_beat", c),
                  128'({bus.out_tid, bus.out_tdata, bus.out_tlast, bus.out_tdest}),
                  128'({5'(exp_id), 64'(exp_id) << 32, 1'b1, 5'(exp_id + 15)}));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
